// File: rtl/axis_frame_generator.sv
// axis_frame_generator: command-driven AXI4-Stream frame source.
// Define AXIS_FRAME_GEN_SUM_EN to add the exp_sum/exp_sum_valid outputs.
module axis_frame_generator #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 10,
    parameter int MAX_LENGTH = 1000,
    parameter int SUM_WIDTH  = 32
) (
    input  logic                              clk,
    input  logic                              resetn,
    output logic                              s_cmd_tready,
    input  logic                              s_cmd_tvalid,
    input  logic [2*DATA_WIDTH+LEN_WIDTH-1:0] s_cmd_tdata,
    input  logic                              m_tready,
    output logic                              m_tvalid,
    output logic [DATA_WIDTH-1:0]             m_tdata,
    output logic                              m_tlast,
    output logic                              busy,
    output logic                              cmd_err
`ifdef AXIS_FRAME_GEN_SUM_EN
    ,
    output logic [SUM_WIDTH-1:0]              exp_sum,
    output logic                              exp_sum_valid
`endif
);

    typedef enum logic {IDLE, SEND} state_e;

    localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LENGTH);
    localparam logic [LEN_WIDTH-1:0] ONE   = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] TWO   = LEN_WIDTH'(2);

    state_e                state_q, state_d;
    logic                  rdy_q, rdy_d;
    logic                  vld_q, vld_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] step_q, step_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;

    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [DATA_WIDTH-1:0] cmd_start;
    logic [DATA_WIDTH-1:0] cmd_step;
    logic                  cmd_hs;
    logic                  cmd_ok;
    logic                  beat_hs;

    assign cmd_len   = s_cmd_tdata[LEN_WIDTH-1:0];
    assign cmd_start = s_cmd_tdata[LEN_WIDTH +: DATA_WIDTH];
    assign cmd_step  = s_cmd_tdata[LEN_WIDTH+DATA_WIDTH +: DATA_WIDTH];
    assign cmd_hs    = s_cmd_tvalid && rdy_q;
    assign cmd_ok    = (cmd_len != '0) && (cmd_len <= MAX_L);
    assign beat_hs   = vld_q && m_tready;

    always_comb begin
        state_d = state_q;
        rdy_d   = rdy_q;
        vld_d   = vld_q;
        data_d  = data_q;
        last_d  = last_q;
        busy_d  = busy_q;
        err_d   = err_q;
        step_d  = step_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (cmd_hs) begin
                    if (cmd_ok) begin
                        state_d = SEND;
                        rdy_d   = 1'b0;
                        vld_d   = 1'b1;
                        data_d  = cmd_start;
                        last_d  = (cmd_len == ONE);
                        busy_d  = 1'b1;
                        step_d  = cmd_step;
                        len_d   = cmd_len;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (beat_hs) begin
                    if (last_q) begin
                        state_d = IDLE;
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        rdy_d   = 1'b1;
                    end else begin
                        data_d = data_q + step_q;
                        cnt_d  = cnt_q + ONE;
                        // next beat is last when its index reaches len-1
                        last_d = (cnt_q + TWO == len_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            step_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            step_q  <= step_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_cmd_tready = rdy_q;
    assign m_tvalid     = vld_q;
    assign m_tdata      = data_q;
    assign m_tlast      = last_q;
    assign busy         = busy_q;
    assign cmd_err      = err_q;

`ifdef AXIS_FRAME_GEN_SUM_EN
    logic [SUM_WIDTH-1:0] acc_q;
    logic [SUM_WIDTH-1:0] sum_q;
    logic                 sum_vld_q;
    logic [SUM_WIDTH-1:0] beat_sx;

    assign beat_sx = {{(SUM_WIDTH-DATA_WIDTH){data_q[DATA_WIDTH-1]}}, data_q};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_q     <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
        end else begin
            sum_vld_q <= 1'b0;
            if (state_q == IDLE && cmd_hs && cmd_ok) begin
                acc_q <= '0;
            end else if (beat_hs) begin
                acc_q <= acc_q + beat_sx;
                if (last_q) begin
                    sum_q     <= acc_q + beat_sx;
                    sum_vld_q <= 1'b1;
                end
            end
        end
    end

    assign exp_sum       = sum_q;
    assign exp_sum_valid = sum_vld_q;
`endif

endmodule
